bist_lfsr_misr: RTL
===================

Name: bist_lfsr_misr

Overview:
Parametrised built-in self-test engine for the tt_um user-design wrapper. An LFSR generates pseudo-random stimulus vectors of configurable width and count. Design responses are compacted into a MISR signature and compared against a golden value. It brings on-chip, self-checking stimulus and response checking into silicon, generalised in width, vector count and response latency.

Parameters:
WIDTH, 8, stimulus/response/signature width (>=3)
POLY, 8'hB8, Galois feedback polynomial (WIDTH bits, used by both LFSR and MISR)
SEED, 8'h01, reset value of the seed register (WIDTH bits)
NUM_VECTORS, 256, vectors per run (>=1)
RESP_LAT, 1, cycles from stimulus issue to response sample (>=0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a run
abort  in  1  terminate the current run
seed_load  in  1  latch seed into the seed register
seed  in  WIDTH  new seed value
golden  in  WIDTH  expected signature
stim_out  out  WIDTH  stimulus vector to the design under test
stim_valid  out  1  stim_out valid this cycle
dut_resp  in  WIDTH  response from the design under test
busy  out  1  run in progress (RUN or DRAIN)
done  out  1  run complete; held until next start
pass  out  1  signature==golden; valid only while done=1
signature  out  WIDTH  current MISR value

Behaviour:
- step(x) = (x>>1) ^ (x[0] ? POLY : 0).
- LFSR: lfsr <= step(lfsr). MISR: misr <= step(misr) ^ dut_resp.
- Reset values:
  - stim_valid=0, busy=0, done=0, pass=0, signature=0.
  - Seed register = SEED; state IDLE.
  - stim_out=0 whenever stim_valid=0.
- Seed load:
  - seed_load is honoured only in IDLE or DONE; ignored while busy.
  - A seed of 0 is stored as 1, because the all-zero state locks the LFSR.
- FSM:
  - IDLE: on start, go to RUN. Same cycle: lfsr <= seed register (or the incoming seed if seed_load is also high), misr <= 0, vector counter <= 0, done <= 0, pass <= 0.
  - RUN, cycle k = 0..NUM_VECTORS-1:
    - stim_valid=1 and stim_out=lfsr (registered).
    - lfsr advances every RUN cycle.
    - After the cycle with k = NUM_VECTORS-1: go to DRAIN if RESP_LAT>0, else DONE.
  - DRAIN: lasts exactly RESP_LAT cycles, stim_valid=0, then go to DONE.
  - DONE: done=1, and pass=(misr==golden) evaluated on entry. golden is sampled on the entry cycle. On start, go to RUN as from IDLE.
- Response capture:
  - stim_valid is delayed through a RESP_LAT-deep shift register (RESP_LAT=0 means no delay).
  - The MISR updates only when the delayed valid is 1, so exactly NUM_VECTORS updates occur per run.
  - The response to vector k is sampled at RUN cycle k+RESP_LAT.
- Interlocks:
  - start while busy is ignored.
  - abort in RUN/DRAIN: go to IDLE next cycle. stim_valid, busy and the delay pipe are cleared; done stays 0; signature holds its partial value.
  - abort in IDLE/DONE has no effect.
  - If abort and start arrive in the same cycle, abort wins.
- Counter width is $clog2(NUM_VECTORS+1).
- Async rst mid-run returns everything to reset values immediately.
- busy = (state==RUN || state==DRAIN), registered.

Test Plan:
- Reset, then start with WIDTH=8, POLY=B8, SEED=01, NUM_VECTORS=5 -> stim_out sequence 01,B8,5C,2E,17 on five consecutive stim_valid cycles; done rises RESP_LAT+1 cycles after the last vector.
- Registered loopback (dut_resp <= stim_out), NUM_VECTORS=4, RESP_LAT=1, golden=00 -> signature=00, pass=1. Repeat with golden=01 -> pass=0.
- seed_load with seed=00 in IDLE, then start -> first stim_out=01. seed_load with seed=A5 while busy -> ignored; next run still starts at the previously stored seed.
- abort two cycles into a NUM_VECTORS=256 run -> busy=0 next cycle, done=0, stim_valid=0. A fresh start then reproduces the full sequence from the seed.
- start pulsed during RUN, and start+abort in the same cycle in RUN -> no restart; abort wins, state goes to IDLE.
- Assert rst in mid-DRAIN -> all outputs at reset values immediately; seed register back to SEED. RESP_LAT=0 build: done follows the last vector by one cycle, with exactly NUM_VECTORS MISR updates.

Source files
------------

// File: rtl/bist_lfsr_misr.sv
// Built-in self-test engine: a Galois LFSR issues a fixed number of stimulus
// vectors, the matching responses are compacted into a MISR signature, and the
// signature is compared against a golden value when the run completes.
module bist_lfsr_misr #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] POLY        = 8'hB8,
    parameter logic [WIDTH-1:0] SEED        = 8'h01,
    parameter int               NUM_VECTORS = 256,
    parameter int               RESP_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] golden,
    output logic [WIDTH-1:0] stim_out,
    output logic             stim_valid,
    input  logic [WIDTH-1:0] dut_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int CW = $clog2(NUM_VECTORS + 1);
    localparam int DW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    localparam logic [CW-1:0]    CNT_LAST   = CW'(NUM_VECTORS - 1);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [DW-1:0]    DRAIN_LAST = (RESP_LAT > 0) ? DW'(RESP_LAT - 1) : {DW{1'b0}};
    localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
    localparam logic [WIDTH-1:0] ZERO_W     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One Galois shift: shared by the stimulus generator and the compactor.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        step = (x >> 1) ^ (x[0] ? POLY : ZERO_W);
    endfunction

    state_t           state_r, state_n_s;
    logic [WIDTH-1:0] seed_r, lfsr_r, misr_r;
    logic [CW-1:0]    cnt_r;
    logic [DW-1:0]    drain_r;
    logic             stim_valid_r, busy_r, done_r, pass_r;
    logic [WIDTH-1:0] stim_out_r;

    logic [WIDTH-1:0] seed_n_s, lfsr_n_s, misr_n_s, stim_out_n_s;
    logic [CW-1:0]    cnt_n_s;
    logic [DW-1:0]    drain_n_s;
    logic             stim_valid_n_s, busy_n_s, done_n_s, pass_n_s;

    logic             idle_like_s, start_go_s, abort_hit_s;
    logic             last_vec_s, drain_last_s, resp_valid_s;
    logic [WIDTH-1:0] seed_fix_s, seed_eff_s;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_fix_s   = (seed == ZERO_W) ? ONE_W : seed;
    assign idle_like_s  = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign start_go_s   = start && !abort && idle_like_s;
    assign abort_hit_s  = abort && !idle_like_s;
    assign seed_eff_s   = seed_load ? seed_fix_s : seed_r;
    assign last_vec_s   = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
    assign drain_last_s = (state_r == ST_DRAIN) && (drain_r == DRAIN_LAST);

    generate
        if (RESP_LAT > 0) begin : g_pipe
            logic [RESP_LAT:1] vpipe_r;
            logic [RESP_LAT:0] vpipe_s;
            assign vpipe_s      = {vpipe_r, stim_valid_r};
            assign resp_valid_s = vpipe_s[RESP_LAT];
            // Delay line that lines up each issued vector with its response.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vpipe_r <= {RESP_LAT{1'b0}};
                end else if (abort_hit_s) begin
                    vpipe_r <= {RESP_LAT{1'b0}};
                end else begin
                    vpipe_r <= vpipe_s[RESP_LAT-1:0];
                end
            end
        end else begin : g_nopipe
            assign resp_valid_s = stim_valid_r;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state decision; abort beats start and end-of-run.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_go_s) state_n_s = ST_RUN;
                else            state_n_s = ST_IDLE;
            end
            ST_RUN: begin
                if (abort_hit_s)     state_n_s = ST_IDLE;
                else if (last_vec_s) state_n_s = (RESP_LAT > 0) ? ST_DRAIN : ST_DONE;
                else                 state_n_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (abort_hit_s)       state_n_s = ST_IDLE;
                else if (drain_last_s) state_n_s = ST_DONE;
                else                   state_n_s = ST_DRAIN;
            end
            ST_DONE: begin
                if (start_go_s) state_n_s = ST_RUN;
                else            state_n_s = ST_DONE;
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs.
    always_comb begin
        lfsr_n_s  = lfsr_r;
        misr_n_s  = misr_r;
        cnt_n_s   = cnt_r;
        seed_n_s  = seed_r;
        drain_n_s = {DW{1'b0}};
        if (start_go_s) begin
            lfsr_n_s = seed_eff_s;
            misr_n_s = ZERO_W;
            cnt_n_s  = {CW{1'b0}};
        end else begin
            if (state_r == ST_RUN) begin
                lfsr_n_s = step(lfsr_r);
                cnt_n_s  = cnt_r + CNT_ONE;
            end else begin
                lfsr_n_s = lfsr_r;
                cnt_n_s  = cnt_r;
            end
            if (resp_valid_s) misr_n_s = step(misr_r) ^ dut_resp;
            else              misr_n_s = misr_r;
        end
        if (state_r == ST_DRAIN) drain_n_s = drain_r + DRAIN_ONE;
        else                     drain_n_s = {DW{1'b0}};
        if (seed_load && idle_like_s) seed_n_s = seed_fix_s;
        else                          seed_n_s = seed_r;

        stim_valid_n_s = (state_n_s == ST_RUN);
        stim_out_n_s   = stim_valid_n_s ? lfsr_n_s : ZERO_W;
        busy_n_s       = (state_n_s == ST_RUN) || (state_n_s == ST_DRAIN);
        done_n_s       = (state_n_s == ST_DONE);
        // The verdict is taken once, on the cycle the run completes.
        if ((state_n_s == ST_DONE) && (state_r != ST_DONE)) pass_n_s = (misr_n_s == golden);
        else if (state_n_s == ST_DONE)                      pass_n_s = pass_r;
        else                                                pass_n_s = 1'b0;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_r       <= SEED;
            lfsr_r       <= SEED;
            misr_r       <= ZERO_W;
            cnt_r        <= {CW{1'b0}};
            drain_r      <= {DW{1'b0}};
            stim_valid_r <= 1'b0;
            stim_out_r   <= ZERO_W;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            seed_r       <= seed_n_s;
            lfsr_r       <= lfsr_n_s;
            misr_r       <= misr_n_s;
            cnt_r        <= cnt_n_s;
            drain_r      <= drain_n_s;
            stim_valid_r <= stim_valid_n_s;
            stim_out_r   <= stim_out_n_s;
            busy_r       <= busy_n_s;
            done_r       <= done_n_s;
            pass_r       <= pass_n_s;
        end
    end

    assign stim_out   = stim_out_r;
    assign stim_valid = stim_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign signature  = misr_r;

endmodule
